// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART command controller: opcodes, FSM state
// encoding and the fixed register-file slots used for ALU operands.
package uart_ctrl_pkg;

  localparam logic [7:0] OP_WRITE   = 8'hAA;
  localparam logic [7:0] OP_READ    = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU_FUN = 8'hDD;

  // Register-file slots that receive the A and B operands of an 0xCC frame
  localparam logic [7:0] ALU_ADDR_A = 8'd0;
  localparam logic [7:0] ALU_ADDR_B = 8'd1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10
  } state_t;

endpackage

// File: rtl/uart_cmd_tx_sender.sv
// Response sender: holds a one- or two-byte response (low byte first) and
// runs the valid/ready handshake toward the UART transmitter.
module uart_cmd_tx_sender #(
  parameter int DSIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               two_bytes,
  input  logic [2*DSIZE-1:0] resp,
  input  logic               tx_ready,
  output logic [DSIZE-1:0]   tx_data,
  output logic               tx_valid,
  output logic               byte_sent,
  output logic               done
);

  logic [DSIZE-1:0] hi_byte;
  logic [1:0]       left;

  assign byte_sent = tx_valid & tx_ready;
  assign done      = byte_sent & (left == 2'd1);

  // Load a new response or advance to the next byte after each handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      hi_byte  <= '0;
      left     <= 2'd0;
    end else if (load) begin
      tx_data  <= resp[DSIZE-1:0];
      hi_byte  <= resp[2*DSIZE-1:DSIZE];
      left     <= two_bytes ? 2'd2 : 2'd1;
      tx_valid <= 1'b1;
    end else if (byte_sent) begin
      if (left == 2'd2) begin
        tx_data <= hi_byte;
        left    <= 2'd1;
      end else begin
        tx_valid <= 1'b0;
        left     <= 2'd0;
      end
    end else begin
      tx_valid <= tx_valid;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes write/read/ALU frames from the received
// byte stream, drives register-file and ALU strobes and sends responses.
// Optional macro RX_ERR_ABORT_EN: bytes flagged with PAR_ERR/STOP_ERR abort
// the current frame and pulse FRAME_ERR; otherwise the flags are ignored.
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int AW    = 4,
  parameter int FW    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DSIZE-1:0]   RX_DATA,
  input  logic               RX_VALID,
  input  logic               PAR_ERR,
  input  logic               STOP_ERR,
  output logic [AW-1:0]      RF_ADDR,
  output logic [DSIZE-1:0]   RF_WR_DATA,
  output logic               RF_WR_EN,
  output logic               RF_RD_EN,
  input  logic [DSIZE-1:0]   RF_RD_DATA,
  input  logic               RF_RD_VALID,
  output logic [FW-1:0]      ALU_FUN,
  output logic               ALU_EN,
  input  logic [2*DSIZE-1:0] ALU_OUT,
  input  logic               ALU_VALID,
  output logic [DSIZE-1:0]   TX_DATA,
  output logic               TX_VALID,
  input  logic               TX_READY,
  output logic               FRAME_ERR,
  output logic               UNK_CMD,
  output logic               OVERRUN
);

  state_t             state;
  logic               load;
  logic               two_bytes;
  logic [2*DSIZE-1:0] resp;
  logic               byte_sent;
  logic               done;
  logic               rx_state;
  logic               frame_abort;

  // States that consume frame bytes, as opposed to waiting or sending
  assign rx_state = (state == IDLE) || (state == WR_ADDR) || (state == WR_DATA) ||
                    (state == RD_ADDR) || (state == OP_A) || (state == OP_B) ||
                    (state == FUN);

`ifdef RX_ERR_ABORT_EN
  assign frame_abort = RX_VALID & rx_state & (PAR_ERR | STOP_ERR);
`else
  logic unused_err;
  assign unused_err  = PAR_ERR ^ STOP_ERR;
  assign frame_abort = 1'b0;
`endif

  // Hand the read byte or the ALU result to the sender when it returns
  always_comb begin
    load      = 1'b0;
    two_bytes = 1'b0;
    resp      = '0;
    if ((state == RD_WAIT) && RF_RD_VALID) begin
      load = 1'b1;
      resp = {{DSIZE{1'b0}}, RF_RD_DATA};
    end else if ((state == ALU_WAIT) && ALU_VALID) begin
      load      = 1'b1;
      two_bytes = 1'b1;
      resp      = ALU_OUT;
    end else begin
      load = 1'b0;
    end
  end

  uart_cmd_tx_sender #(.DSIZE(DSIZE)) u_tx (
    .clk       (CLK),
    .rst       (RST),
    .load      (load),
    .two_bytes (two_bytes),
    .resp      (resp),
    .tx_ready  (TX_READY),
    .tx_data   (TX_DATA),
    .tx_valid  (TX_VALID),
    .byte_sent (byte_sent),
    .done      (done)
  );

  // Frame decoder FSM with registered strobes and event pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      FRAME_ERR  <= 1'b0;
      UNK_CMD    <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      RF_WR_EN  <= 1'b0;
      RF_RD_EN  <= 1'b0;
      ALU_EN    <= 1'b0;
      FRAME_ERR <= 1'b0;
      UNK_CMD   <= 1'b0;
      OVERRUN   <= 1'b0;
      if (frame_abort) begin
        FRAME_ERR <= 1'b1;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: if (RX_VALID) begin
            case (RX_DATA)
              OP_WRITE:   state   <= WR_ADDR;
              OP_READ:    state   <= RD_ADDR;
              OP_ALU_OPS: state   <= OP_A;
              OP_ALU_FUN: state   <= FUN;
              default:    UNK_CMD <= 1'b1;
            endcase
          end
          WR_ADDR: if (RX_VALID) begin
            RF_ADDR <= RX_DATA[AW-1:0];
            state   <= WR_DATA;
          end
          WR_DATA: if (RX_VALID) begin
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= IDLE;
          end
          RD_ADDR: if (RX_VALID) begin
            RF_ADDR  <= RX_DATA[AW-1:0];
            RF_RD_EN <= 1'b1;
            state    <= RD_WAIT;
          end
          RD_WAIT: begin
            OVERRUN <= RX_VALID;
            if (RF_RD_VALID) state <= TX_LO;
          end
          OP_A: if (RX_VALID) begin
            RF_ADDR    <= ALU_ADDR_A[AW-1:0];
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= OP_B;
          end
          OP_B: if (RX_VALID) begin
            RF_ADDR    <= ALU_ADDR_B[AW-1:0];
            RF_WR_DATA <= RX_DATA;
            RF_WR_EN   <= 1'b1;
            state      <= FUN;
          end
          FUN: if (RX_VALID) begin
            ALU_FUN <= RX_DATA[FW-1:0];
            ALU_EN  <= 1'b1;
            state   <= ALU_WAIT;
          end
          ALU_WAIT: begin
            OVERRUN <= RX_VALID;
            if (ALU_VALID) state <= TX_LO;
          end
          TX_LO: begin
            OVERRUN <= RX_VALID;
            if (byte_sent) state <= done ? IDLE : TX_HI;
          end
          TX_HI: begin
            OVERRUN <= RX_VALID;
            if (byte_sent) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_uart_cmd_ctrl;

  localparam int DSIZE = 8;
  localparam int AW    = 4;
  localparam int FW    = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [DSIZE-1:0]   RX_DATA = '0;
  logic               RX_VALID = 1'b0;
  logic               PAR_ERR = 1'b0;
  logic               STOP_ERR = 1'b0;
  logic [AW-1:0]      RF_ADDR;
  logic [DSIZE-1:0]   RF_WR_DATA;
  logic               RF_WR_EN;
  logic               RF_RD_EN;
  logic [DSIZE-1:0]   RF_RD_DATA = '0;
  logic               RF_RD_VALID = 1'b0;
  logic [FW-1:0]      ALU_FUN;
  logic               ALU_EN;
  logic [2*DSIZE-1:0] ALU_OUT = '0;
  logic               ALU_VALID = 1'b0;
  logic [DSIZE-1:0]   TX_DATA;
  logic               TX_VALID;
  logic               TX_READY = 1'b0;
  logic               FRAME_ERR;
  logic               UNK_CMD;
  logic               OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_pulses  = 0;
  int rd_pulses  = 0;
  int alu_pulses = 0;

  uart_cmd_ctrl #(.DSIZE(DSIZE), .AW(AW), .FW(FW)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .PAR_ERR(PAR_ERR), .STOP_ERR(STOP_ERR), .RF_ADDR(RF_ADDR),
    .RF_WR_DATA(RF_WR_DATA), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VALID(RF_RD_VALID), .ALU_FUN(ALU_FUN),
    .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .FRAME_ERR(FRAME_ERR), .UNK_CMD(UNK_CMD), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Count strobe cycles so tests can verify that nothing extra fired
  always @(posedge CLK) begin
    if (RF_WR_EN) wr_pulses <= wr_pulses + 1;
    if (RF_RD_EN) rd_pulses <= rd_pulses + 1;
    if (ALU_EN) alu_pulses <= alu_pulses + 1;
  end

  // Present one byte for one cycle; returns on the falling edge after capture
  task automatic drive_byte(input logic [7:0] b, input logic perr);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    PAR_ERR  = perr;
    @(negedge CLK);
    RX_VALID = 1'b0;
    PAR_ERR  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({RF_WR_EN, RF_RD_EN, ALU_EN, TX_VALID, FRAME_ERR, UNK_CMD, OVERRUN} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {RF_WR_EN, RF_RD_EN, ALU_EN, TX_VALID, FRAME_ERR, UNK_CMD, OVERRUN});
    end
    n_checks++;
    if ({RF_ADDR, RF_WR_DATA, ALU_FUN, TX_DATA} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected 000000", {RF_ADDR, RF_WR_DATA, ALU_FUN, TX_DATA});
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_write();
    int w0;
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'h05, 1'b0);
    w0 = wr_pulses;
    drive_byte(8'h3C, 1'b0);
    n_checks++;
    if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h5, 8'h3C}) begin
      n_fail++;
      $display("FAIL write_strobe: got en=%b addr=%h data=%h expected en=1 addr=5 data=3c",
               RF_WR_EN, RF_ADDR, RF_WR_DATA);
    end
    @(negedge CLK);
    n_checks++;
    if (RF_WR_EN !== 1'b0 || (wr_pulses - w0) != 1) begin
      n_fail++;
      $display("FAIL write_one_cycle: got en=%b pulses=%0d expected en=0 pulses=1",
               RF_WR_EN, wr_pulses - w0);
    end
    n_checks++;
    if (TX_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_tx: got %b expected 0", TX_VALID);
    end
  endtask

  task automatic test_read();
    drive_byte(8'hBB, 1'b0);
    drive_byte(8'h05, 1'b0);
    n_checks++;
    if ({RF_RD_EN, RF_ADDR} !== {1'b1, 4'h5}) begin
      n_fail++;
      $display("FAIL read_strobe: got en=%b addr=%h expected en=1 addr=5", RF_RD_EN, RF_ADDR);
    end
    @(negedge CLK);
    @(negedge CLK);
    RF_RD_DATA  = 8'h3C;
    RF_RD_VALID = 1'b1;
    TX_READY    = 1'b0;
    @(negedge CLK);
    RF_RD_VALID = 1'b0;
    RF_RD_DATA  = 8'h00;
    repeat (4) begin
      n_checks++;
      if ({TX_VALID, TX_DATA} !== {1'b1, 8'h3C}) begin
        n_fail++;
        $display("FAIL read_tx_hold: got valid=%b data=%h expected valid=1 data=3c", TX_VALID, TX_DATA);
      end
      @(negedge CLK);
    end
    TX_READY = 1'b1;
    @(negedge CLK);
    TX_READY = 1'b0;
    n_checks++;
    if (TX_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL read_tx_single: got valid=%b expected 0", TX_VALID);
    end
  endtask

  task automatic test_alu();
    TX_READY = 1'b1;
    drive_byte(8'hCC, 1'b0);
    drive_byte(8'h12, 1'b0);
    n_checks++;
    if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h0, 8'h12}) begin
      n_fail++;
      $display("FAIL alu_op_a: got en=%b addr=%h data=%h expected en=1 addr=0 data=12",
               RF_WR_EN, RF_ADDR, RF_WR_DATA);
    end
    drive_byte(8'h34, 1'b0);
    n_checks++;
    if ({RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b1, 4'h1, 8'h34}) begin
      n_fail++;
      $display("FAIL alu_op_b: got en=%b addr=%h data=%h expected en=1 addr=1 data=34",
               RF_WR_EN, RF_ADDR, RF_WR_DATA);
    end
    drive_byte(8'h02, 1'b0);
    n_checks++;
    if ({ALU_EN, ALU_FUN, RF_WR_EN} !== {1'b1, 4'h2, 1'b0}) begin
      n_fail++;
      $display("FAIL alu_start: got en=%b fun=%h wr=%b expected en=1 fun=2 wr=0", ALU_EN, ALU_FUN, RF_WR_EN);
    end
    @(negedge CLK);
    n_checks++;
    if (ALU_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_en_one_cycle: got %b expected 0", ALU_EN);
    end
    ALU_OUT   = 16'h0246;
    ALU_VALID = 1'b1;
    @(negedge CLK);
    ALU_VALID = 1'b0;
    ALU_OUT   = 16'h0000;
    n_checks++;
    if ({TX_VALID, TX_DATA} !== {1'b1, 8'h46}) begin
      n_fail++;
      $display("FAIL alu_tx_lo: got valid=%b data=%h expected valid=1 data=46", TX_VALID, TX_DATA);
    end
    @(negedge CLK);
    n_checks++;
    if ({TX_VALID, TX_DATA} !== {1'b1, 8'h02}) begin
      n_fail++;
      $display("FAIL alu_tx_hi: got valid=%b data=%h expected valid=1 data=02", TX_VALID, TX_DATA);
    end
    @(negedge CLK);
    n_checks++;
    if (TX_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_tx_end: got valid=%b expected 0", TX_VALID);
    end
    TX_READY = 1'b0;
  endtask

  task automatic test_unknown();
    int s0;
    s0 = wr_pulses + rd_pulses + alu_pulses;
    drive_byte(8'h55, 1'b0);
    n_checks++;
    if (UNK_CMD !== 1'b1) begin
      n_fail++;
      $display("FAIL unk_pulse: got %b expected 1", UNK_CMD);
    end
    ALU_OUT     = 16'hFFFF;
    ALU_VALID   = 1'b1;
    RF_RD_VALID = 1'b1;
    @(negedge CLK);
    ALU_VALID   = 1'b0;
    RF_RD_VALID = 1'b0;
    ALU_OUT     = 16'h0000;
    n_checks++;
    if (UNK_CMD !== 1'b0) begin
      n_fail++;
      $display("FAIL unk_one_cycle: got %b expected 0", UNK_CMD);
    end
    @(negedge CLK);
    n_checks++;
    if (TX_VALID !== 1'b0 || (wr_pulses + rd_pulses + alu_pulses) != s0) begin
      n_fail++;
      $display("FAIL unk_no_side_effects: got tx_valid=%b strobes=%0d expected tx_valid=0 strobes=0",
               TX_VALID, wr_pulses + rd_pulses + alu_pulses - s0);
    end
  endtask

  task automatic test_overrun();
    drive_byte(8'hDD, 1'b0);
    drive_byte(8'h03, 1'b0);
    n_checks++;
    if ({ALU_EN, ALU_FUN} !== {1'b1, 4'h3}) begin
      n_fail++;
      $display("FAIL ovr_alu_start: got en=%b fun=%h expected en=1 fun=3", ALU_EN, ALU_FUN);
    end
    drive_byte(8'h77, 1'b0);
    n_checks++;
    if ({OVERRUN, RF_WR_EN, ALU_EN} !== 3'b100) begin
      n_fail++;
      $display("FAIL ovr_alu_wait: got ovr/wr/alu=%b expected 100", {OVERRUN, RF_WR_EN, ALU_EN});
    end
    ALU_OUT   = 16'h1234;
    ALU_VALID = 1'b1;
    @(negedge CLK);
    ALU_VALID = 1'b0;
    n_checks++;
    if ({OVERRUN, TX_VALID, TX_DATA} !== {1'b0, 1'b1, 8'h34}) begin
      n_fail++;
      $display("FAIL ovr_result_lo: got ovr=%b valid=%b data=%h expected ovr=0 valid=1 data=34",
               OVERRUN, TX_VALID, TX_DATA);
    end
    drive_byte(8'h88, 1'b0);
    n_checks++;
    if ({OVERRUN, TX_VALID, TX_DATA} !== {1'b1, 1'b1, 8'h34}) begin
      n_fail++;
      $display("FAIL ovr_tx_lo: got ovr=%b valid=%b data=%h expected ovr=1 valid=1 data=34",
               OVERRUN, TX_VALID, TX_DATA);
    end
    TX_READY = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({TX_VALID, TX_DATA} !== {1'b1, 8'h12}) begin
      n_fail++;
      $display("FAIL ovr_result_hi: got valid=%b data=%h expected valid=1 data=12", TX_VALID, TX_DATA);
    end
    @(negedge CLK);
    TX_READY = 1'b0;
    n_checks++;
    if (TX_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_tx_end: got valid=%b expected 0", TX_VALID);
    end
  endtask

  task automatic test_frame_err();
    int w0;
    w0 = wr_pulses;
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'h05, 1'b0);
    drive_byte(8'h3C, 1'b1);
`ifdef RX_ERR_ABORT_EN
    n_checks++;
    if ({FRAME_ERR, RF_WR_EN} !== 2'b10) begin
      n_fail++;
      $display("FAIL ferr_abort: got ferr=%b wr=%b expected ferr=1 wr=0", FRAME_ERR, RF_WR_EN);
    end
    @(negedge CLK);
    drive_byte(8'h55, 1'b0);
    n_checks++;
    if (UNK_CMD !== 1'b1 || wr_pulses != w0) begin
      n_fail++;
      $display("FAIL ferr_back_idle: got unk=%b writes=%0d expected unk=1 writes=0", UNK_CMD, wr_pulses - w0);
    end
`else
    n_checks++;
    if ({FRAME_ERR, RF_WR_EN, RF_ADDR, RF_WR_DATA} !== {1'b0, 1'b1, 4'h5, 8'h3C}) begin
      n_fail++;
      $display("FAIL ferr_ignored: got ferr=%b wr=%b addr=%h data=%h expected ferr=0 wr=1 addr=5 data=3c",
               FRAME_ERR, RF_WR_EN, RF_ADDR, RF_WR_DATA);
    end
    @(negedge CLK);
    n_checks++;
    if (wr_pulses - w0 != 1) begin
      n_fail++;
      $display("FAIL ferr_write_count: got %0d expected 1", wr_pulses - w0);
    end
`endif
  endtask

  task automatic test_rst_mid_frame();
    drive_byte(8'hCC, 1'b0);
    drive_byte(8'h12, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if ({RF_WR_EN, RF_RD_EN, ALU_EN, TX_VALID, FRAME_ERR, UNK_CMD, OVERRUN} !== 7'b0 ||
        {RF_ADDR, RF_WR_DATA, ALU_FUN, TX_DATA} !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got strobes=%b values=%h expected strobes=0 values=000000",
               {RF_WR_EN, RF_RD_EN, ALU_EN, TX_VALID, FRAME_ERR, UNK_CMD, OVERRUN},
               {RF_ADDR, RF_WR_DATA, ALU_FUN, TX_DATA});
    end
    drive_byte(8'hDD, 1'b0);
    drive_byte(8'h01, 1'b0);
    n_checks++;
    if ({ALU_EN, ALU_FUN, RF_WR_EN} !== {1'b1, 4'h1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_then_alu: got en=%b fun=%h wr=%b expected en=1 fun=1 wr=0", ALU_EN, ALU_FUN, RF_WR_EN);
    end
    @(negedge CLK);
    ALU_OUT   = 16'h00AB;
    ALU_VALID = 1'b1;
    TX_READY  = 1'b1;
    @(negedge CLK);
    ALU_VALID = 1'b0;
    n_checks++;
    if ({TX_VALID, TX_DATA} !== {1'b1, 8'hAB}) begin
      n_fail++;
      $display("FAIL rst_then_tx_lo: got valid=%b data=%h expected valid=1 data=ab", TX_VALID, TX_DATA);
    end
    @(negedge CLK);
    n_checks++;
    if ({TX_VALID, TX_DATA} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_then_tx_hi: got valid=%b data=%h expected valid=1 data=00", TX_VALID, TX_DATA);
    end
    @(negedge CLK);
    TX_READY = 1'b0;
    n_checks++;
    if (TX_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_then_tx_end: got valid=%b expected 0", TX_VALID);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_unknown();
    test_overrun();
    test_frame_err();
    test_rst_mid_frame();
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
